// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 requester.
//   apb_state_e : requester FSM encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
//   apb_req_t   : latched command payload driven onto the APB bus
//   C_PPROT_*   : bit positions inside pprot
package apb_pkg;

  localparam int unsigned C_DATA_WIDTH = 32;
  localparam int unsigned C_STRB_WIDTH = C_DATA_WIDTH / 8;

  localparam int unsigned C_PPROT_PRIV   = 0;
  localparam int unsigned C_PPROT_NONSEC = 1;
  localparam int unsigned C_PPROT_INSTR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                    write;
    logic [2:0]              prot;
    logic [C_STRB_WIDTH-1:0] strb;
    logic [C_DATA_WIDTH-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog for apb_master_if (used only with APB_MASTER_TIMEOUT_EN).
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : hold count at zero (requester not in ACCESS)
//   inc_i        : one stalled ACCESS cycle (pready low)
//   last_o       : registered; current cycle is the G_TIMEOUT-th stalled cycle
module apb_timeout_cnt #(
  parameter int unsigned G_TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int unsigned C_CNT_W = $clog2(G_TIMEOUT + 1);

  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               last_q;

  // Next count: cleared outside ACCESS, advanced on each stalled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + C_CNT_W'(1);
    end
  end

  // Flag precomputed one cycle early so expiry needs no compare in the top's path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= (cnt_d == C_CNT_W'(G_TIMEOUT - 1));
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/apb_master_if.sv
// APB4 requester: single-beat client commands (valid/ready) become APB
// SETUP/ACCESS transfers; read data and error return on a valid/ready
// response channel. One transfer outstanding at a time.
// Optional macro APB_MASTER_TIMEOUT_EN: abort ACCESS after G_TIMEOUT stalled cycles.
//   pclk_i, preset_i       : clock, synchronous active-high reset
//   cmd_*                  : command channel (valid/ready, write, addr, wdata, strb, prot)
//   rsp_*                  : response channel (valid/ready, rdata, err)
//   p*_o                   : APB requester outputs (all registered)
//   pready_i, prdata_i, pslverr_i : APB completer inputs
module apb_master_if
  import apb_pkg::*;
#(
  parameter int unsigned G_APB_ADDR_WIDTH = 8,
  parameter int unsigned G_TIMEOUT        = 256
) (
  input  logic                        pclk_i,
  input  logic                        preset_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_write_i,
  input  logic [G_APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [C_DATA_WIDTH-1:0]     cmd_wdata_i,
  input  logic [C_STRB_WIDTH-1:0]     cmd_strb_i,
  input  logic [2:0]                  cmd_prot_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [C_DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic [G_APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [2:0]                  pprot_o,
  output logic                        psel_o,
  output logic                        penable_o,
  output logic                        pwrite_o,
  output logic [C_DATA_WIDTH-1:0]     pwdata_o,
  output logic [C_STRB_WIDTH-1:0]     pstrb_o,
  input  logic                        pready_i,
  input  logic [C_DATA_WIDTH-1:0]     prdata_i,
  input  logic                        pslverr_i
);

  apb_state_e                  state_q;
  apb_req_t                    req_q;
  logic [G_APB_ADDR_WIDTH-1:0] paddr_q;
  logic                        cmd_ready_q;
  logic                        psel_q;
  logic                        penable_q;
  logic                        rsp_valid_q;
  logic                        rsp_err_q;
  logic [C_DATA_WIDTH-1:0]     rsp_rdata_q;
  logic                        timeout_c;

`ifdef APB_MASTER_TIMEOUT_EN
  logic to_last;

  apb_timeout_cnt #(
    .G_TIMEOUT(G_TIMEOUT)
  ) u_timeout_cnt (
    .clk_i  (pclk_i),
    .rst_i  (preset_i),
    .clr_i  (state_q != ST_ACCESS),
    .inc_i  ((state_q == ST_ACCESS) && !pready_i),
    .last_o (to_last)
  );

  // A late pready on the expiry cycle still completes normally.
  assign timeout_c = (state_q == ST_ACCESS) && !pready_i && to_last;
`else
  localparam int unsigned C_UNUSED_TIMEOUT = G_TIMEOUT;
  assign timeout_c = 1'b0;
`endif

  // Requester FSM with registered bus and response outputs.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      paddr_q     <= '0;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            paddr_q     <= cmd_addr_i;
            req_q.write <= cmd_write_i;
            req_q.prot  <= cmd_prot_i;
            req_q.wdata <= cmd_wdata_i;
            req_q.strb  <= cmd_write_i ? cmd_strb_i : '0;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            rsp_rdata_q <= req_q.write ? '0 : prdata_i;
            rsp_err_q   <= pslverr_i;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (timeout_c) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign paddr_o     = paddr_q;
  assign pprot_o     = req_q.prot;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = req_q.write;
  assign pwdata_o    = req_q.wdata;
  assign pstrb_o     = req_q.strb;

endmodule
